alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the CPU's 4-bit combinational ALU: WIDTH-bit datapath with registered result and flags.
- Adds multi-cycle operations: iterative shifts and shift-add multiply with high and low halves.
- Sits between the register-file read stage and writeback. Uses valid/ready on both sides so the control FSM can stall on multi-cycle ops.

Parameters:
- WIDTH, 4, datapath width in bits. Must be a power of two, ≥ 2.
- SAW, $clog2(WIDTH), shift-amount width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- op  in  4  opcode; sampled on accept.
- rx  in  WIDTH  operand A; sampled on accept.
- ry  in  WIDTH  operand B; sampled on accept.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes the result.
- out  out  WIDTH  result.
- z  out  1  zero flag.
- n  out  1  negative flag (out MSB).
- c  out  1  carry/borrow flag.
- v  out  1  signed overflow flag.
- busy  out  1  state is BUSY.

Behaviour:
- Reset (async assert, release synchronous to clk): state=IDLE, out=0, z=n=c=v=0, out_valid=0, busy=0, internal counters/operands cleared. Reset mid-operation aborts the operation; no result is produced.
- FSM states: IDLE, BUSY, DONE.
- Handshake:
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - Accept = in_valid && in_ready.
  - Result handoff = out_valid && out_ready.
  - out_valid = (state==DONE).
- Transitions:
  - Accept of a single-cycle op → DONE next cycle.
  - Accept of a multi-cycle op → BUSY.
  - BUSY → DONE when the iteration count is exhausted.
  - DONE with out_ready: on simultaneous accept, go to DONE/BUSY for the new op; otherwise go to IDLE.
- DONE without out_ready: out and flags held stable, in_ready=0, in_valid ignored.
- Opcodes (s = ry[SAW-1:0]):
  - 0 ADD: rx+ry.
  - 1 SUB: rx-ry.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 NOT rx.
  - 6 SHL rx by s.
  - 7 SHR (logical) rx by s.
  - 8 ASR rx by s.
  - 9 MUL: low WIDTH bits of the unsigned product.
  - A MULH: high WIDTH bits of the unsigned product.
  - B CMP: flags as SUB, out=rx.
  - C INC: rx+1.
  - D DEC: rx-1.
  - E PASS ry.
  - F PASS rx.
- Latency, accept edge to out_valid:
  - Single-cycle ops (0-5, B-F): 1 cycle.
  - Shifts: 1+s cycles, one bit per BUSY cycle. s=0 completes in 1 cycle with out=rx.
  - MUL/MULH: WIDTH+1 cycles, one shift-add per BUSY cycle.
  - Back-to-back single-cycle ops with out_ready=1 sustain one result per cycle.
- Arithmetic: all WIDTH bits, wrap-around modulo 2^WIDTH.
- Flags (registered with out, updated only on entering DONE):
  - z = (out==0). For CMP, z = (rx-ry==0).
  - n = MSB of out. For CMP, n = MSB of rx-ry.
  - c:
    - ADD/INC: carry-out.
    - SUB/CMP/DEC: borrow (rx<ry unsigned; DEC: rx==0).
    - Shifts: last bit shifted out, 0 if s=0.
    - MUL: 1 if high half ≠ 0.
    - MULH: 0.
    - Others: 0.
  - v:
    - ADD/INC: signed overflow (operands same sign, result sign differs).
    - SUB/CMP/DEC: signed overflow (operands differ in sign, result sign differs from rx).
    - Others: 0.
- Operands and op are latched on accept; input changes during BUSY/DONE have no effect.

Test Plan:
1. WIDTH=4, ADD rx=0111 ry=0001 → out_valid 1 cycle after accept. out=1000, z=0, n=1, c=0, v=1.
2. WIDTH=4:
   - SUB 0101-0101 → out=0000, z=1, c=0, v=0.
   - SUB 0001-0010 → out=1111, n=1, c=1.
   - CMP 0001,0010 → out=0001, n=1, c=1.
3. WIDTH=4:
   - MUL rx=0110 ry=0011 → out_valid after 5 cycles, busy=1 for 4 cycles, out=0010, c=1.
   - MULH same operands → out=0001, c=0.
4. WIDTH=4:
   - SHL rx=0011 ry=0110 (s=2) → latency 3, out=1100, c=0.
   - ASR rx=1001 ry=0001 → latency 2, out=1100, c=1.
   - SHR with s=0 → latency 1, out=rx, c=0.
5. Backpressure:
   - Hold out_ready=0 for 3 cycles in DONE → out/flags stable, in_ready=0.
   - Then out_ready=1 with in_valid=1 (XOR 1010,0110) in the same cycle → accepted, out=1100 next cycle.
   - Stream 4 ADDs with out_ready=1 → 4 results on 4 consecutive cycles.
6. Reset mid-MUL: drop rst_n on the 2nd BUSY cycle → out_valid, busy, out and flags go 0 immediately (async). After release, in_ready=1 and no stale result appears. WIDTH=8 repeat of scenario 3 with 200×3 → out=0x58, c=1, latency 9.

Source files
------------

// File: rtl/alu_seq_if.sv
// Purpose: request/result bundle for alu_seq. The master drives operations and the slave returns results.
// Latency: none. This file contains only wiring.
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
// Ports: in_valid, in_ready, op, rx, ry (request); out_valid, out_ready, out, z, n, c, v (result); busy (status).
interface alu_seq_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] rx;
  logic [WIDTH-1:0] ry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             z;
  logic             n;
  logic             c;
  logic             v;
  logic             busy;

  modport master (
    output in_valid, op, rx, ry, out_ready,
    input  in_ready, out_valid, out, z, n, c, v, busy
  );

  modport slave (
    input  in_valid, op, rx, ry, out_ready,
    output in_ready, out_valid, out, z, n, c, v, busy
  );
endinterface

// File: rtl/alu_seq.sv
// Purpose: WIDTH-bit sequential ALU with a registered result and flags, iterative shifts and a shift-add multiply.
// Latency: single-cycle ops take 1 cycle, shifts take 1+s cycles, and MUL/MULH take WIDTH+1 cycles (accept to out_valid).
// Backpressure: the result is held in DONE until out_ready. in_ready is high only when IDLE or when DONE is being drained.
// Ports: clk, rst_n (asynchronous, active-low); bus (alu_seq_if.slave) carries the request and result handshakes and busy.
module alu_seq #(
  parameter int WIDTH = 4
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);
  localparam int SAW = $clog2(WIDTH);
  localparam int CW  = SAW + 1;  // wide enough to hold WIDTH

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR   = 4'h3,
                         OP_XOR = 4'h4, OP_NOT = 4'h5, OP_SHL = 4'h6, OP_SHR  = 4'h7,
                         OP_ASR = 4'h8, OP_MUL = 4'h9, OP_MULH = 4'hA, OP_CMP = 4'hB,
                         OP_INC = 4'hC, OP_DEC = 4'hD, OP_PASSY = 4'hE;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

  state_t             state;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q;      // holds the shifting operand, or the multiplicand for MUL/MULH
  logic [2*WIDTH-1:0] p_q;      // product register: {partial high, remaining multiplier bits}
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   out_q;
  flags_t             flg_q;
  logic               out_valid_q;
  logic               busy_q;

  // Request decode
  logic           in_ready_c, accept;
  logic [SAW-1:0] s_in;
  logic           is_shift_in, is_mul_in, multi_in;

  assign in_ready_c  = (state == IDLE) || (state == DONE && bus.out_ready);
  assign accept      = bus.in_valid && in_ready_c;
  assign s_in        = bus.ry[SAW-1:0];
  assign is_shift_in = bus.op inside {OP_SHL, OP_SHR, OP_ASR};
  assign is_mul_in   = bus.op inside {OP_MUL, OP_MULH};
  // A zero-distance shift has nothing to iterate, so it takes the single-cycle path.
  assign multi_in    = is_mul_in || (is_shift_in && s_in != '0);

  // Shared adder/subtractor for ADD, SUB, CMP, INC and DEC
  logic [WIDTH-1:0] as_b;
  logic             as_sub;
  logic [WIDTH:0]   as_r;
  logic             as_v;

  always_comb begin
    as_b   = bus.ry;
    as_sub = 1'b0;
    case (bus.op)
      OP_SUB, OP_CMP: as_sub = 1'b1;
      OP_INC:         as_b   = WIDTH'(1);
      OP_DEC: begin
        as_b   = WIDTH'(1);
        as_sub = 1'b1;
      end
      default: ;
    endcase
  end

  // The top bit is the carry-out when adding and the borrow when subtracting.
  assign as_r = as_sub ? ({1'b0, bus.rx} - {1'b0, as_b}) : ({1'b0, bus.rx} + {1'b0, as_b});
  // Overflow requires equal operand signs for addition and opposite signs for subtraction,
  // together with a result sign that differs from rx.
  assign as_v = ((bus.rx[WIDTH-1] ^ as_b[WIDTH-1]) == as_sub) &&
                (as_r[WIDTH-1] != bus.rx[WIDTH-1]);

  // Single-cycle results
  logic [WIDTH-1:0] sc_res, sc_fv;
  logic             sc_c, sc_v;

  always_comb begin
    sc_res = bus.rx;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (bus.op)
      OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
        sc_res = as_r[WIDTH-1:0];
        sc_c   = as_r[WIDTH];
        sc_v   = as_v;
      end
      OP_AND:   sc_res = bus.rx & bus.ry;
      OP_OR:    sc_res = bus.rx | bus.ry;
      OP_XOR:   sc_res = bus.rx ^ bus.ry;
      OP_NOT:   sc_res = ~bus.rx;
      OP_CMP: begin
        sc_c = as_r[WIDTH];
        sc_v = as_v;
      end
      OP_PASSY: sc_res = bus.ry;
      default: ;  // PASS rx and zero-distance shifts return rx
    endcase
  end

  // CMP returns rx but takes z and n from the difference.
  assign sc_fv = (bus.op == OP_CMP) ? as_r[WIDTH-1:0] : sc_res;

  // One iteration step per BUSY cycle
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] p_nxt;
  logic [WIDTH-1:0]   sh_nxt, bs_res;
  logic               sh_co, bs_c;

  assign mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
  assign p_nxt   = {mul_sum, p_q[WIDTH-1:1]};

  always_comb begin
    sh_nxt = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
    sh_co  = a_q[0];
    case (op_q)
      OP_SHL: begin
        sh_nxt = {a_q[WIDTH-2:0], 1'b0};
        sh_co  = a_q[WIDTH-1];
      end
      OP_SHR: sh_nxt = {1'b0, a_q[WIDTH-1:1]};
      default: ;  // ASR
    endcase
    bs_res = sh_nxt;
    bs_c   = sh_co;
    if (op_q == OP_MUL) begin
      bs_res = p_nxt[WIDTH-1:0];
      bs_c   = |p_nxt[2*WIDTH-1:WIDTH];
    end else if (op_q == OP_MULH) begin
      bs_res = p_nxt[2*WIDTH-1:WIDTH];
      bs_c   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      p_q         <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      flg_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (accept) begin
      op_q <= bus.op;
      a_q  <= bus.rx;
      p_q  <= {{WIDTH{1'b0}}, bus.ry};
      if (multi_in) begin
        state       <= BUSY;
        busy_q      <= 1'b1;
        out_valid_q <= 1'b0;
        cnt_q       <= is_mul_in ? CW'(WIDTH) : CW'(s_in);
      end else begin
        state       <= DONE;
        busy_q      <= 1'b0;
        out_valid_q <= 1'b1;
        out_q       <= sc_res;
        flg_q.z     <= (sc_fv == '0);
        flg_q.n     <= sc_fv[WIDTH-1];
        flg_q.c     <= sc_c;
        flg_q.v     <= sc_v;
      end
    end else if (state == BUSY) begin
      cnt_q <= cnt_q - CW'(1);
      if (op_q inside {OP_MUL, OP_MULH}) p_q <= p_nxt;
      else                               a_q <= sh_nxt;
      // The final step writes its result directly into the output registers.
      if (cnt_q == CW'(1)) begin
        state       <= DONE;
        busy_q      <= 1'b0;
        out_valid_q <= 1'b1;
        out_q       <= bs_res;
        flg_q.z     <= (bs_res == '0);
        flg_q.n     <= bs_res[WIDTH-1];
        flg_q.c     <= bs_c;
        flg_q.v     <= 1'b0;
      end
    end else if (state == DONE && bus.out_ready) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.out       = out_q;
  assign bus.z         = flg_q.z;
  assign bus.n         = flg_q.n;
  assign bus.c         = flg_q.c;
  assign bus.v         = flg_q.v;
endmodule

// File: tb/tb_alu_seq.sv
// Purpose: directed self-checking bench for alu_seq at WIDTH=4 and WIDTH=8.
// Latency: measured from the accept edge until out_valid is observed (#1 after each rising edge).
// Backpressure: includes DONE hold with out_ready low, accept while draining, and back-to-back streaming.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(4)) b4();
  alu_seq_if #(.WIDTH(8)) b8();

  alu_seq #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  alu_seq #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

  logic [3:0] srx  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b0111};
  logic [3:0] sry  [4] = '{4'b0001, 4'b0011, 4'b0100, 4'b0111};
  logic [3:0] sexp [4] = '{4'b0010, 4'b0101, 4'b1000, 4'b1110};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op from IDLE and wait (bounded) until out_valid is seen.
  task automatic run4(input logic [3:0] op, input logic [3:0] rx, input logic [3:0] ry,
                      output int lat, output int bcyc);
    b4.op = op; b4.rx = rx; b4.ry = ry; b4.in_valid = 1'b1; b4.out_ready = 1'b1;
    @(posedge clk); #1;
    b4.in_valid = 1'b0;
    lat = 1; bcyc = 0;
    while (!b4.out_valid && lat < 64) begin
      if (b4.busy) bcyc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run8(input logic [3:0] op, input logic [7:0] rx, input logic [7:0] ry,
                      output int lat, output int bcyc);
    b8.op = op; b8.rx = rx; b8.ry = ry; b8.in_valid = 1'b1; b8.out_ready = 1'b1;
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    lat = 1; bcyc = 0;
    while (!b8.out_valid && lat < 64) begin
      if (b8.busy) bcyc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // One row of the vector table: out, flags {z,n,c,v}, latency, and the number of busy cycles.
  task automatic vec4(input string tag, input logic [3:0] op, input logic [3:0] rx,
                      input logic [3:0] ry, input logic [3:0] eout, input logic [3:0] eflg,
                      input int elat);
    int lat, bc;
    run4(op, rx, ry, lat, bc);
    check({tag, " valid"}, b4.out_valid, 1);
    check({tag, " out"},   b4.out, eout);
    check({tag, " flags"}, {b4.z, b4.n, b4.c, b4.v}, eflg);
    check({tag, " lat"},   lat, elat);
    check({tag, " busy"},  bc, elat - 1);
    @(posedge clk); #1;  // handoff, so the DUT returns to IDLE
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, bc, stale;
    rst_n = 1'b0;
    b4.in_valid = 1'b0; b4.out_ready = 1'b1; b4.op = '0; b4.rx = '0; b4.ry = '0;
    b8.in_valid = 1'b0; b8.out_ready = 1'b1; b8.op = '0; b8.rx = '0; b8.ry = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst out_valid", b4.out_valid, 0);
    check("rst busy", b4.busy, 0);
    check("rst out", b4.out, 0);
    check("rst flags", {b4.z, b4.n, b4.c, b4.v}, 0);
    check("rst in_ready", b4.in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    //   tag         op     rx       ry       out      zncv     lat
    vec4("add",      4'h0, 4'b0111, 4'b0001, 4'b1000, 4'b0101, 1);
    vec4("add_wrap", 4'h0, 4'b1111, 4'b0001, 4'b0000, 4'b1010, 1);
    vec4("sub_eq",   4'h1, 4'b0101, 4'b0101, 4'b0000, 4'b1000, 1);
    vec4("sub_brw",  4'h1, 4'b0001, 4'b0010, 4'b1111, 4'b0110, 1);
    vec4("sub_ovf",  4'h1, 4'b1000, 4'b0001, 4'b0111, 4'b0001, 1);
    vec4("and",      4'h2, 4'b1100, 4'b1010, 4'b1000, 4'b0100, 1);
    vec4("or",       4'h3, 4'b1100, 4'b0010, 4'b1110, 4'b0100, 1);
    vec4("xor",      4'h4, 4'b1010, 4'b0110, 4'b1100, 4'b0100, 1);
    vec4("not",      4'h5, 4'b1010, 4'b0000, 4'b0101, 4'b0000, 1);
    vec4("shl2",     4'h6, 4'b0011, 4'b0110, 4'b1100, 4'b0100, 3);
    vec4("shl1",     4'h6, 4'b1011, 4'b0001, 4'b0110, 4'b0010, 2);
    vec4("shr3",     4'h7, 4'b1000, 4'b0011, 4'b0001, 4'b0000, 4);
    vec4("shr0",     4'h7, 4'b1011, 4'b0100, 4'b1011, 4'b0100, 1);
    vec4("asr1",     4'h8, 4'b1001, 4'b0001, 4'b1100, 4'b0110, 2);
    vec4("asr3",     4'h8, 4'b1000, 4'b0011, 4'b1111, 4'b0100, 4);
    vec4("mul",      4'h9, 4'b0110, 4'b0011, 4'b0010, 4'b0010, 5);
    vec4("mulh",     4'hA, 4'b0110, 4'b0011, 4'b0001, 4'b0000, 5);
    vec4("mul_ff",   4'h9, 4'b1111, 4'b1111, 4'b0001, 4'b0010, 5);
    vec4("mulh_ff",  4'hA, 4'b1111, 4'b1111, 4'b1110, 4'b0100, 5);
    vec4("cmp",      4'hB, 4'b0001, 4'b0010, 4'b0001, 4'b0110, 1);
    vec4("cmp_eq",   4'hB, 4'b0011, 4'b0011, 4'b0011, 4'b1000, 1);
    vec4("inc",      4'hC, 4'b0111, 4'b0000, 4'b1000, 4'b0101, 1);
    vec4("dec0",     4'hD, 4'b0000, 4'b0000, 4'b1111, 4'b0110, 1);
    vec4("dec_ovf",  4'hD, 4'b1000, 4'b0000, 4'b0111, 4'b0001, 1);
    vec4("passy",    4'hE, 4'b0011, 4'b1001, 4'b1001, 4'b0100, 1);
    vec4("passx",    4'hF, 4'b0011, 4'b1001, 4'b0011, 4'b0000, 1);

    // Hold DONE with out_ready low while a conflicting request is presented.
    b4.op = 4'h0; b4.rx = 4'b0011; b4.ry = 4'b0100; b4.in_valid = 1'b1; b4.out_ready = 1'b0;
    @(posedge clk); #1;
    b4.op = 4'h1; b4.rx = 4'b1111; b4.ry = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      check("bp valid", b4.out_valid, 1);
      check("bp in_ready", b4.in_ready, 0);
      check("bp out", b4.out, 4'b0111);
      check("bp flags", {b4.z, b4.n, b4.c, b4.v}, 4'b0000);
      @(posedge clk); #1;
    end
    b4.op = 4'h4; b4.rx = 4'b1010; b4.ry = 4'b0110; b4.out_ready = 1'b1;
    #1;
    check("bp in_ready drain", b4.in_ready, 1);
    @(posedge clk); #1;
    check("bp xor valid", b4.out_valid, 1);
    check("bp xor out", b4.out, 4'b1100);
    check("bp xor flags", {b4.z, b4.n, b4.c, b4.v}, 4'b0100);

    // Stream back-to-back ADDs, expecting one result per cycle.
    for (int k = 0; k < 4; k++) begin
      b4.op = 4'h0; b4.rx = srx[k]; b4.ry = sry[k]; b4.in_valid = 1'b1;
      @(posedge clk); #1;
      check("stream valid", b4.out_valid, 1);
      check("stream out", b4.out, sexp[k]);
    end
    b4.in_valid = 1'b0;
    @(posedge clk); #1;
    check("stream idle", b4.out_valid, 0);

    // Assert reset asynchronously on the second BUSY cycle of a MUL.
    b4.op = 4'h9; b4.rx = 4'b0110; b4.ry = 4'b0011; b4.in_valid = 1'b1;
    @(posedge clk); #1;
    b4.in_valid = 1'b0;
    @(posedge clk); #1;
    check("rmul busy pre", b4.busy, 1);
    rst_n = 1'b0;
    #1;
    check("rmul out_valid", b4.out_valid, 0);
    check("rmul busy", b4.busy, 0);
    check("rmul out", b4.out, 0);
    check("rmul flags", {b4.z, b4.n, b4.c, b4.v}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rmul in_ready", b4.in_ready, 1);
    stale = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (b4.out_valid) stale = 1;
    end
    check("rmul no stale", stale, 0);

    // Repeat the multiply checks at WIDTH=8: 200*3 = 600 = 0x258.
    run8(4'h9, 8'd200, 8'd3, lat, bc);
    check("mul8 valid", b8.out_valid, 1);
    check("mul8 out", b8.out, 8'h58);
    check("mul8 flags", {b8.z, b8.n, b8.c, b8.v}, 4'b0010);
    check("mul8 lat", lat, 9);
    check("mul8 busy", bc, 8);
    @(posedge clk); #1;
    run8(4'hA, 8'd200, 8'd3, lat, bc);
    check("mulh8 valid", b8.out_valid, 1);
    check("mulh8 out", b8.out, 8'h02);
    check("mulh8 flags", {b8.z, b8.n, b8.c, b8.v}, 4'b0000);
    check("mulh8 lat", lat, 9);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
